nios_spi_pio_in: RTL and testbench

//  Parametrised Avalon-MM input PIO for the Nios SPI subsystem; successor to the 1-bit read-only input port.

---
 rtl/nios_spi_pio_in.sv | 132 +++++++++++++
 tb/tb_nios_spi_pio_in.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_spi_pio_in.sv
// Avalon-MM input PIO: synchronised status lines, sticky edge capture (W1C), maskable level irq.
// Latency: in_port -> DATA/EDGECAP SYNC_STAGES+1 clks; register read 1 clk (readdata registered every clk).
// Backpressure: none; slave accepts every access with no wait states. Optional IRQ mask/output under `PIO_IRQ_EN.
module nios_spi_pio_in #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] RST_VEC = (RESET_VALUE != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] w1c_clr;
    logic             wr_stb;
    logic [31:0]      rd_mux;

    // Only the low WIDTH bits of writedata carry register content.
    logic             unused_wdat;
    assign unused_wdat = ^writedata;

    assign wr_stb = chipselect & ~write_n;

    // Multi-flop synchroniser for the asynchronous status lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= RST_VEC;
            end
        end else begin
            sync_chain[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
        end
    end

    assign sync_q = sync_chain[SYNC_STAGES-1];

    // One-clock delayed copy of the synchronised lines for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= RST_VEC;
        end else begin
            d_q <= sync_q;
        end
    end

    // Select which transition marks an event on each line.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = sync_q & ~d_q;
            1:       edge_det = ~sync_q & d_q;
            default: edge_det = sync_q ^ d_q;
        endcase
    end

    // Bits to clear from a write-one-to-clear access on EDGECAP.
    always_comb begin
        w1c_clr = '0;
        if (wr_stb && (address == 2'd3)) begin
            w1c_clr = writedata[WIDTH-1:0];
        end
    end

    // Sticky capture; a new edge in the same cycle as its clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~w1c_clr) | edge_det;
        end
    end

`ifdef PIO_IRQ_EN
    logic [WIDTH-1:0] irq_mask;

    // Interrupt enable per line, written through IRQMASK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (wr_stb && (address == 2'd2)) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Level interrupt built only from flops, so it follows reset asynchronously.
    assign irq = |(edge_capture & irq_mask);
`else
    assign irq = 1'b0;
`endif

    // Zero-extended register read mux.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0] = sync_q;
            2'd2: begin
`ifdef PIO_IRQ_EN
                rd_mux[WIDTH-1:0] = irq_mask;
`endif
            end
            2'd3: rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    // Read data registered every clock, no read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_nios_spi_pio_in.sv
module tb_nios_spi_pio_in;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int ET = 0;
    localparam int RV = 0;
`ifdef PIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   readdata;
    logic          irq;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model state: history of in_port as sampled at each clock edge.
    logic [W-1:0]  hist [$];
    logic [W-1:0]  m_cap;
    logic [W-1:0]  m_mask;
    logic [31:0]   m_rd;
    logic          m_irq;

    nios_spi_pio_in #(
        .WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(ET), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] edges(input logic [W-1:0] now_v, input logic [W-1:0] before_v);
        case (ET)
            0:       return now_v & ~before_v;
            1:       return ~now_v & before_v;
            default: return now_v ^ before_v;
        endcase
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < SS + 2; i++) hist.push_back((RV != 0) ? {W{1'b1}} : {W{1'b0}});
        m_cap  = '0;
        m_mask = '0;
        m_rd   = '0;
        m_irq  = 1'b0;
    endfunction

    // One bus cycle: drive, let the DUT clock once, advance the model, compare at the falling edge.
    task automatic cyc(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        logic [W-1:0] seen, seen_prev;
        logic         wr;
        address = a; chipselect = cs; write_n = wn; writedata = wd;
        @(posedge clk);
        hist.push_back(in_port);
        seen      = hist[hist.size()-1-SS];
        seen_prev = hist[hist.size()-2-SS];
        void'(hist.pop_front());
        case (a)
            2'd0: m_rd = 32'(seen);
            2'd2: m_rd = IRQ_EN ? 32'(m_mask) : 32'd0;
            2'd3: m_rd = 32'(m_cap);
            default: m_rd = 32'd0;
        endcase
        wr = cs & ~wn;
        m_cap = (m_cap & ~((wr && a == 2'd3) ? wd[W-1:0] : '0)) | edges(seen, seen_prev);
        if (IRQ_EN && wr && a == 2'd2) m_mask = wd[W-1:0];
        m_irq = IRQ_EN && ((m_cap & m_mask) != '0);
        @(negedge clk);
        chk("model_readdata", readdata, m_rd);
        chk("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) cyc(a, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        cyc(a, 1'b1, 1'b0, wd);
    endtask

    // Called just after a falling edge; asserts reset between clock edges.
    task automatic do_reset(input logic [W-1:0] pin);
        in_port = pin;
        #2 reset = 1'b1;
        #1;
        chk("rst_async_irq", 32'(irq), 32'd0);
        chk("rst_async_rd", readdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_rd", readdata, 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset with all lines high, EDGECAP empty right after release.
        do_reset(8'hFF);
        cyc(2'd3, 1'b0, 1'b1, 32'd0);
        chk("rst_edgecap", readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        // Settle lines low and clear whatever the release captured.
        in_port = 8'h00;
        idle(SS + 3, 2'd0);
        wr(2'd3, 32'hFF);
        idle(1, 2'd3);
        chk("cap_cleared", readdata, 32'd0);

        // Synchroniser latency on DATA.
        in_port = 8'h5A;
        idle(SS, 2'd0);
        chk("sync_early", readdata, 32'd0);
        idle(1, 2'd0);
        chk("sync_lat", readdata, 32'h5A);

        // Rising-edge capture of a single pulse, then W1C.
        in_port = 8'h00;
        idle(SS + 2, 2'd0);
        wr(2'd3, 32'hFF);
        in_port = 8'h08;
        idle(1, 2'd3);
        in_port = 8'h00;
        idle(SS + 2, 2'd3);
        chk("rise_cap", readdata, 32'h08);
        idle(1, 2'd3);
        chk("read_no_clear", readdata, 32'h08);
        wr(2'd3, 32'h08);
        idle(1, 2'd3);
        chk("w1c_clear", readdata, 32'd0);
        idle(1, 2'd1);
        chk("addr1_zero", readdata, 32'd0);

`ifdef PIO_IRQ_EN
        // Masked interrupt behaviour.
        wr(2'd2, 32'h08);
        idle(1, 2'd2);
        chk("mask_rb", readdata, 32'h08);
        in_port = 8'h08;
        idle(1, 2'd3);
        in_port = 8'h00;
        idle(SS + 2, 2'd3);
        chk("irq_bit3", 32'(irq), 32'd1);
        wr(2'd3, 32'h08);
        chk("irq_w1c", 32'(irq), 32'd0);
        in_port = 8'h01;
        idle(1, 2'd3);
        in_port = 8'h00;
        idle(SS + 2, 2'd3);
        chk("irq_bit0_masked", 32'(irq), 32'd0);
        chk("cap_bit0", readdata, 32'h01);
        wr(2'd3, 32'hFF);

        // Clear and new rise on bit 1 land on the same clock: set wins.
        wr(2'd2, 32'h02);
        in_port = 8'h02;
        idle(SS + 2, 2'd0);
        chk("irq_bit1", 32'(irq), 32'd1);
        in_port = 8'h00;
        idle(SS + 2, 2'd0);
        in_port = 8'h02;
        idle(SS, 2'd0);
        wr(2'd3, 32'h02);
        chk("coll_irq", 32'(irq), 32'd1);
        idle(1, 2'd3);
        chk("coll_cap", readdata, 32'h02);
`else
        // Without the irq option, IRQMASK is absent and irq stays low.
        wr(2'd2, 32'hFF);
        idle(1, 2'd2);
        chk("mask_off_rb", readdata, 32'd0);
        in_port = 8'hFF;
        idle(1, 2'd3);
        in_port = 8'h00;
        idle(SS + 2, 2'd3);
        chk("mask_off_irq", 32'(irq), 32'd0);
        chk("mask_off_cap", readdata, 32'hFF);
        in_port = 8'h02;
        idle(SS + 2, 2'd3);
`endif

        // Reset in the middle of operation drops pending captures.
        do_reset(8'h00);
        idle(1, 2'd3);
        chk("rst_lost", readdata, 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) in_port = W'($urandom);
            cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
